sysmm_sched: RTL

- Sequencer for the 3x3 output-stationary systolic MAC array.
- Accepts one 3x3 x 3x3 matrix-multiply job per valid/ready handshake and latches both operand matrices.
- Clears the PE accumulators, drives the skewed row/column feed wavefronts, waits for the array to drain, then captures the nine sums and holds them until the consumer takes them.
- Replaces free-running step counters with a job-based controller that supports back-to-back jobs and backpressure.

---
 rtl/sysmm_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sysmm_sched.sv
// Job sequencer for the 3x3 output-stationary systolic MAC array: clear, skewed feed, drain, capture.
// Latency: handshake at edge T -> pe_clr in T+1 -> feed steps T+2..T+6 -> out_valid from T+7+DRAIN_CYC.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_valid & out_ready, then back to IDLE.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     job handshake; in1 = A (A[r][k] at (3r+k)*DW), in2 = B (B[k][c] at (3k+c)*DW)
//   pe_clr                one-cycle clear of PE accumulators and pass-through registers
//   row_feed/col_feed     left-edge (row r at r*DW) and top-edge (column c at c*DW) operand wavefronts
//   sum_in                live array sums, PE(r,c) at (3r+c)*AW
//   out_valid/out_ready   result handshake; out_data holds the captured sums (same layout as sum_in)
//   busy                  high in every state other than IDLE
//   acc_mode              (only with SYSMM_ACCUM_EN) skip the clear so products accumulate onto the
//                         previous job's sums; the first job after reset always clears
//
// Optional feature macro: SYSMM_ACCUM_EN (undefined: no acc_mode port, every job clears).

module sysmm_sched #(
    parameter int DW        = 4,
    parameter int AW        = 8,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9*DW-1:0]   in1,
    input  logic [9*DW-1:0]   in2,
`ifdef SYSMM_ACCUM_EN
    input  logic              acc_mode,
`endif
    output logic              pe_clr,
    output logic [3*DW-1:0]   row_feed,
    output logic [3*DW-1:0]   col_feed,
    input  logic [9*AW-1:0]   sum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9*AW-1:0]   out_data,
    output logic              busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam int         DCW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC - 1);
    localparam logic [2:0] LAST_STEP = 3'd4;

    logic [2:0]        state;
    logic [2:0]        step;
    logic [DCW-1:0]    dcnt;
    logic [9*DW-1:0]   a_q;
    logic [9*DW-1:0]   b_q;

`ifdef SYSMM_ACCUM_EN
    // Set once the array has been cleared since reset; until then the PE
    // contents are unknown, so accumulate requests are forced to clear.
    logic primed;
`endif

    // Left-edge wavefront for step k: row r carries A[r][k-r] while that index is in range.
    function automatic logic [3*DW-1:0] feed_row(input logic [9*DW-1:0] m, input logic [2:0] k);
        logic [3*DW-1:0] v;
        int j;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            j = int'(k) - r;
            if (j >= 0 && j <= 2)
                v[r*DW +: DW] = m[(3*r + j)*DW +: DW];
        end
        return v;
    endfunction

    // Top-edge wavefront for step k: column c carries B[k-c][c] while that index is in range.
    function automatic logic [3*DW-1:0] feed_col(input logic [9*DW-1:0] m, input logic [2:0] k);
        logic [3*DW-1:0] v;
        int j;
        v = '0;
        for (int c = 0; c < 3; c++) begin
            j = int'(k) - c;
            if (j >= 0 && j <= 2)
                v[c*DW +: DW] = m[(3*j + c)*DW +: DW];
        end
        return v;
    endfunction

    // Every output is a register loaded with the value for the state being
    // entered, so the outputs line up cycle-for-cycle with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            dcnt      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b0;
            pe_clr    <= 1'b0;
            row_feed  <= '0;
            col_feed  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef SYSMM_ACCUM_EN
            primed    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        step     <= '0;
`ifdef SYSMM_ACCUM_EN
                        if (acc_mode && primed) begin
                            // Operands are not in a_q/b_q yet; take step 0 straight from the inputs.
                            state    <= S_FEED;
                            row_feed <= feed_row(in1, 3'd0);
                            col_feed <= feed_col(in2, 3'd0);
                        end else begin
                            state  <= S_CLEAR;
                            pe_clr <= 1'b1;
                        end
`else
                        state  <= S_CLEAR;
                        pe_clr <= 1'b1;
`endif
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    pe_clr   <= 1'b0;
                    state    <= S_FEED;
                    step     <= '0;
                    row_feed <= feed_row(a_q, 3'd0);
                    col_feed <= feed_col(b_q, 3'd0);
`ifdef SYSMM_ACCUM_EN
                    primed   <= 1'b1;
`endif
                end

                S_FEED: begin
                    // step holds the step currently on the feeds.
                    if (step == LAST_STEP) begin
                        state    <= S_DRAIN;
                        dcnt     <= '0;
                        row_feed <= '0;
                        col_feed <= '0;
                    end else begin
                        step     <= step + 3'd1;
                        row_feed <= feed_row(a_q, step + 3'd1);
                        col_feed <= feed_col(b_q, step + 3'd1);
                    end
                end

                S_DRAIN: begin
                    // Last product reaches PE(2,2) after two hops plus its MAC register.
                    if (dcnt == DRAIN_LAST) begin
                        out_data  <= sum_in;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    pe_clr    <= 1'b0;
                    row_feed  <= '0;
                    col_feed  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
